conv_channel_injector: RTL

//  Channel-model stage between the rate-1/2 convolutional encoder and the Viterbi decoder.

---
 rtl/chan_pkg.sv | 23 ++
 rtl/chan_lfsr.sv | 21 ++
 rtl/conv_channel_injector.sv | 114 +++++++++++
 3 files changed

// File: rtl/chan_pkg.sv
// Shared types and constants for the convolutional channel-model injector.
package chan_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    PERIODIC = 2'd1,
    RANDOM   = 2'd2,
    BURST    = 2'd3
  } chan_mode_e;

  // State names carry a prefix so they do not clash with the BURST mode enumerator.
  typedef enum logic {
    BST_IDLE  = 1'b0,
    BST_BURST = 1'b1
  } burst_st_e;

  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[1]} + {1'b0, m[0]};
  endfunction

endpackage

// File: rtl/chan_lfsr.sv
// 16-bit right-shifting Galois LFSR; advances once per adv_i pulse.
module chan_lfsr
  import chan_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv_i,
  output logic [15:0] q_o
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_o <= SEED;
    end else if (adv_i) begin
      q_o <= {1'b0, q_o[15:1]} ^ (q_o[0] ? LFSR_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/conv_channel_injector.sv
// Channel-model stage: registers each valid encoder symbol and XORs in a pass/periodic/random/burst
// error mask. Define INJ_STATS_EN to build the symbol and bit-error counters and clr_i.
module conv_channel_injector
  import chan_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 16,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       d_i,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       thresh_i,
  input  logic [3:0]       burst_len_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [1:0]       d_o,
  output logic [1:0]       err_o,
  output logic [CNT_W-1:0] sym_ct_o,
  output logic [CNT_W-1:0] bit_err_ct_o
);

  logic [15:0]      lfsr;
  logic [CNT_W-1:0] sym_idx_q;
  burst_st_e        st_q;
  logic [3:0]       bcnt_q;
  logic [3:0]       blen_q;
  logic             trig;
  logic [1:0]       mask;

  chan_lfsr #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv_i (valid_i),
    .q_o   (lfsr)
  );

  always_comb begin
    trig = &sym_idx_q[N-1:0];
    mask = 2'b00;
    case (chan_mode_e'(mode_i))
      PASS:     mask = 2'b00;
      PERIODIC: mask = trig ? 2'b11 : 2'b00;
      RANDOM:   mask = {lfsr[15:8] < thresh_i, lfsr[7:0] < thresh_i};
      BURST:    mask = (st_q == BST_BURST || trig) ? 2'b11 : 2'b00;
      default:  mask = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_o   <= 1'b0;
      d_o       <= 2'b00;
      err_o     <= 2'b00;
      sym_idx_q <= '0;
      st_q      <= BST_IDLE;
      bcnt_q    <= 4'd0;
      blen_q    <= 4'd0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        d_o       <= d_i ^ mask;
        err_o     <= mask;
        sym_idx_q <= sym_idx_q + 1'b1;
      end
      if (mode_i != BURST) begin
        st_q <= BST_IDLE;
      end else if (valid_i) begin
        if (st_q == BST_IDLE) begin
          // A one-symbol burst is fully covered by the trigger symbol itself.
          if (trig && burst_len_i > 4'd1) begin
            st_q   <= BST_BURST;
            bcnt_q <= 4'd1;
            blen_q <= burst_len_i;
          end
        end else begin
          if (bcnt_q + 4'd1 == blen_q) st_q <= BST_IDLE;
          bcnt_q <= bcnt_q + 4'd1;
        end
      end
    end
  end

`ifdef INJ_STATS_EN
  logic [CNT_W-1:0] sym_ct_q;
  logic [CNT_W-1:0] bit_ct_q;
  logic [CNT_W:0]   bit_sum;

  assign bit_sum = {1'b0, bit_ct_q} + (CNT_W + 1)'(popcount2(mask));

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      sym_ct_q <= '0;
      bit_ct_q <= '0;
    end else if (valid_i) begin
      if (sym_ct_q != '1) sym_ct_q <= sym_ct_q + 1'b1;
      bit_ct_q <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
  end

  assign sym_ct_o     = sym_ct_q;
  assign bit_err_ct_o = bit_ct_q;
`else
  logic unused_clr;
  assign unused_clr   = clr_i;
  assign sym_ct_o     = '0;
  assign bit_err_ct_o = '0;
`endif

endmodule
